// File: rtl/bcd_down_timer.sv
// bcd_down_timer: cascaded BCD down-counter with per-digit mod-6/mod-10, load sanitising and done pulse.
// Optional BCD_DOWN_TIMER_AUTO_RELOAD_EN reloads the last loaded value when the count expires.
module bcd_down_timer #(
    parameter int                DIGITS    = 4,
    parameter logic [DIGITS-1:0] MOD6_MASK = 4'b0010,
    parameter int                WRAP      = 0
) (
    input  logic                  clk,
    input  logic                  clrn,
    input  logic                  loadn,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   data,
    output logic [4*DIGITS-1:0]   out,
    output logic                  zero,
    output logic                  done
);
    localparam int W = 4 * DIGITS;

    logic [W-1:0] out_q, out_d;
    logic         done_q, done_d;
    logic [W-1:0] san, dec, maxv, reload_val;
    logic [3:0]   nib, mx, dnib;
    logic         borrow, cnt_done;

`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
    logic [W-1:0] reload_q, reload_d;

    always_comb reload_d = loadn ? reload_q : san;

    always_ff @(posedge clk or negedge clrn)
        if (!clrn) reload_q <= '0;
        else       reload_q <= reload_d;

    assign reload_val = reload_q;
`else
    assign reload_val = '0;
`endif

    // Per-digit sanitise, all-max pattern and borrow-rippled decrement
    always_comb begin
        san    = '0;
        dec    = '0;
        maxv   = '0;
        nib    = '0;
        mx     = '0;
        dnib   = '0;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            nib             = out_q[4*i+:4];
            mx              = MOD6_MASK[i] ? 4'd5 : 4'd9;
            dnib            = data[4*i+:4];
            san[4*i+:4]     = (dnib > mx) ? mx : dnib;
            maxv[4*i+:4]    = mx;
            dec[4*i+:4]     = borrow ? ((nib == 4'd0) ? mx : nib - 4'd1) : nib;
            borrow          = borrow && (nib == 4'd0);
        end
    end

    assign zero     = (out_q == '0);
    assign cnt_done = !zero && (dec == '0);

    always_comb begin
        out_d  = out_q;
        done_d = 1'b0;
        if (!loadn)
            out_d = san;
        else if (en && zero)
            out_d = (WRAP != 0 && reload_val == '0) ? maxv : out_q;
        else if (en) begin
            out_d  = cnt_done ? reload_val : dec;
            done_d = cnt_done;
        end
    end

    always_ff @(posedge clk or negedge clrn)
        if (!clrn) begin
            out_q  <= '0;
            done_q <= 1'b0;
        end else begin
            out_q  <= out_d;
            done_q <= done_d;
        end

    assign out  = out_q;
    assign done = done_q;
endmodule

// File: tb/tb_bcd_down_timer.sv
// tb_bcd_down_timer: directed checks of the default timer plus a WRAP=1 instance sharing its inputs.
module tb_bcd_down_timer;
`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif
    logic        clk = 1'b0, clrn, loadn, en;
    logic [15:0] data, out, out_w;
    logic        zero, done, zero_w, done_w;
    int          total = 0, passed = 0;

    always #5 clk = ~clk;

    bcd_down_timer dut (.clk(clk), .clrn(clrn), .loadn(loadn), .en(en), .data(data),
                        .out(out), .zero(zero), .done(done));
    bcd_down_timer #(.WRAP(1)) dut_w (.clk(clk), .clrn(clrn), .loadn(loadn), .en(en), .data(data),
                        .out(out_w), .zero(zero_w), .done(done_w));

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [15:0] v);
        loadn = 1'b0;
        data  = v;
        tick();
        loadn = 1'b1;
    endtask

    initial begin
        clrn = 1'b1; loadn = 1'b1; en = 1'b0; data = '0;
        #3 clrn = 1'b0;
        #1;
        chk("rst_out", out, 16'h0000);
        chk("rst_zero", {15'd0, zero}, 16'd1);
        chk("rst_done", {15'd0, done}, 16'd0);
        #2 clrn = 1'b1;
        load(16'h0130);
        chk("load_0130", out, 16'h0130);
        en = 1'b1;
        tick(); chk("cnt_0129", out, 16'h0129);
        tick(); chk("cnt_0128", out, 16'h0128);
        tick(); chk("cnt_0127", out, 16'h0127);
        load(16'h1000);
        chk("load_1000", out, 16'h1000);
        tick(); chk("borrow_0959", out, 16'h0959);
        load(16'h0100);
        tick(); chk("borrow_0059", out, 16'h0059);
        chk("nz_zero", {15'd0, zero}, 16'd0);
        load(16'h0002);
        chk("load_0002", out, 16'h0002);
        chk("load_nodone", {15'd0, done}, 16'd0);
        tick(); chk("cnt_0001", out, 16'h0001);
        chk("pre_done", {15'd0, done}, 16'd0);
        tick(); chk("done_out", out, AR ? 16'h0002 : 16'h0000);
        chk("done_pulse", {15'd0, done}, 16'd1);
        chk("done_zero", {15'd0, zero}, AR ? 16'd0 : 16'd1);
        en = 1'b0;
        tick(); chk("hold_out", out, AR ? 16'h0002 : 16'h0000);
        chk("done_clear", {15'd0, done}, 16'd0);
        load(16'h0000);
        chk("load0_out", out, 16'h0000);
        chk("load0_nodone", {15'd0, done}, 16'd0);
        chk("load0_zero", {15'd0, zero}, 16'd1);
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("sat_out", out, 16'h0000);
            chk("sat_done", {15'd0, done}, 16'd0);
        end
        chk("sat_zero", {15'd0, zero}, 16'd1);
        loadn = 1'b0; data = 16'hFAC7;
        tick(); chk("sanitise", out, 16'h9957);
        loadn = 1'b1;
        tick(); chk("post_san", out, 16'h9956);
        load(16'h0003);
        chk("ar_load", out, 16'h0003);
        tick(); chk("ar_0002", out, 16'h0002);
        tick(); chk("ar_0001", out, 16'h0001);
        tick(); chk("ar_done_out", out, AR ? 16'h0003 : 16'h0000);
        chk("ar_done", {15'd0, done}, 16'd1);
        tick(); chk("ar_next", out, AR ? 16'h0002 : 16'h0000);
        chk("ar_done_clr", {15'd0, done}, 16'd0);
        #2 clrn = 1'b0;
        #1;
        chk("mid_rst_out", out, 16'h0000);
        chk("mid_rst_w", out_w, 16'h0000);
        chk("mid_rst_done", {15'd0, done}, 16'd0);
        #2 clrn = 1'b1;
        tick(); chk("post_rst_out", out, 16'h0000);
        chk("post_rst_done", {15'd0, done}, 16'd0);
        chk("wrap_9959", out_w, 16'h9959);
        chk("wrap_nodone", {15'd0, done_w}, 16'd0);
        tick(); chk("wrap_9958", out_w, 16'h9958);
        chk("post_rst_out2", out, 16'h0000);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
